// File: rtl/iob_fifo_w_wide_r_narrow.sv
// Width-converting FIFO: one wide word in per write, RATIO narrow words out, lane 0 first.
// Full/empty come only from the registered level, so a same-cycle read never makes room for a write.
module iob_fifo_w_wide_r_narrow #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int R_ADDR_W = 6
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_valid,
  output logic                r_empty,
  output logic [R_ADDR_W:0]   level
);

  localparam int RATIO    = W_DATA_W / R_DATA_W;
  localparam int LANE_W   = $clog2(RATIO);
  localparam int W_ADDR_W = R_ADDR_W - LANE_W;
  localparam int DEPTH    = 2 ** R_ADDR_W;

  localparam logic [R_ADDR_W:0] FULL_THR  = (R_ADDR_W + 1)'(DEPTH - RATIO);
  localparam logic [R_ADDR_W:0] LVL_WR    = (R_ADDR_W + 1)'(RATIO);
  localparam logic [R_ADDR_W:0] LVL_RD    = (R_ADDR_W + 1)'(1);
  localparam logic [R_ADDR_W:0] LVL_WR_RD = (R_ADDR_W + 1)'(RATIO - 1);

  logic [R_DATA_W-1:0] mem [DEPTH];

  logic [W_ADDR_W-1:0] wptr_q, wptr_d;
  logic [R_ADDR_W-1:0] rptr_q, rptr_d;
  logic [R_ADDR_W:0]   level_q, level_d;
  logic [R_DATA_W-1:0] r_data_q, r_data_d;
  logic                r_valid_q, r_valid_d;

  logic                w_acc;
  logic                r_acc;
  logic [R_ADDR_W-1:0] w_base;

  assign w_full  = (level_q > FULL_THR);
  assign r_empty = (level_q == '0);
  assign w_acc   = w_en && !w_full;
  assign r_acc   = r_en && !r_empty;
  assign w_base  = R_ADDR_W'(wptr_q) << LANE_W;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;
    r_data_d  = r_data_q;
    r_valid_d = r_acc;
    if (w_acc) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (r_acc) begin
      rptr_d   = rptr_q + 1'b1;
      r_data_d = mem[rptr_q];
    end
    unique case ({w_acc, r_acc})
      2'b10:   level_d = level_q + LVL_WR;
      2'b01:   level_d = level_q - LVL_RD;
      2'b11:   level_d = level_q + LVL_WR_RD;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end
  end

  // Storage has no reset so it can map onto a RAM.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int i = 0; i < RATIO; i++) begin
        mem[w_base + R_ADDR_W'(i)] <= w_data[i*R_DATA_W +: R_DATA_W];
      end
    end
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;
  assign level   = level_q;

endmodule

// File: tb/tb_iob_fifo_w_wide_r_narrow.sv
// Directed bench for the 32->8 FIFO with 16 narrow slots.
module tb_iob_fifo_w_wide_r_narrow;

  logic        clk;
  logic        arst_n;
  logic        w_en;
  logic [31:0] w_data;
  logic        w_full;
  logic        r_en;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_empty;
  logic [4:0]  level;

  int n_tests = 0;
  int n_fail  = 0;

  iob_fifo_w_wide_r_narrow #(
    .W_DATA_W(32),
    .R_DATA_W(8),
    .R_ADDR_W(4)
  ) dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .w_en    (w_en),
    .w_data  (w_data),
    .w_full  (w_full),
    .r_en    (r_en),
    .r_data  (r_data),
    .r_valid (r_valid),
    .r_empty (r_empty),
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  lvl;
    logic        full;
    logic        empty;
    logic        rv;
    logic [7:0]  rd;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input int we, input logic [31:0] wd, input int re, input int lvl,
                              input int full, input int empty, input int rv, input int rd);
    vec_t t;
    t.we    = 1'(we);
    t.wd    = wd;
    t.re    = 1'(re);
    t.lvl   = 5'(lvl);
    t.full  = 1'(full);
    t.empty = 1'(empty);
    t.rv    = 1'(rv);
    t.rd    = 8'(rd);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int lvl, input int full, input int empty,
                           input int rv, input int rd);
    chk({tag, " level"},   32'(level),   32'(lvl));
    chk({tag, " w_full"},  32'(w_full),  32'(full));
    chk({tag, " r_empty"}, 32'(r_empty), 32'(empty));
    chk({tag, " r_valid"}, 32'(r_valid), 32'(rv));
    chk({tag, " r_data"},  32'(r_data),  32'(rd));
  endtask

  // One clock with the given requests; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic we, input logic [31:0] wd, input logic re);
    w_en   = we;
    w_data = wd;
    r_en   = re;
    @(posedge clk);
    #1;
    w_en   = 1'b0;
    r_en   = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0;
    w_en   = 1'b0;
    w_data = '0;
    r_en   = 1'b0;

    // Order, full, simultaneous and ignored-write rows.
    tv.push_back(mk(1, 32'hDDCCBBAA, 0, 4, 0, 0, 0, 8'h00));
    for (int j = 0; j < 4; j++)
      tv.push_back(mk(0, 32'h0, 1, 3 - j, 0, int'(j == 3), 1, 8'hAA + j * 8'h11));
    tv.push_back(mk(0, 32'h0, 0, 0, 0, 1, 0, 8'hDD));
    for (int k = 0; k < 4; k++)
      tv.push_back(mk(1, 32'h13121110 + 32'(k) * 32'h04040404, 0, 4 * (k + 1), int'(k == 3), 0, 0, 8'hDD));
    tv.push_back(mk(1, 32'hEEEEEEEE, 0, 16, 1, 0, 0, 8'hDD));
    for (int j = 0; j < 12; j++)
      tv.push_back(mk(0, 32'h0, 1, 15 - j, int'((15 - j) > 12), 0, 1, 8'h10 + j));
    tv.push_back(mk(1, 32'h23222120, 1, 7, 0, 0, 1, 8'h1C));
    tv.push_back(mk(1, 32'h27262524, 0, 11, 0, 0, 0, 8'h1C));
    tv.push_back(mk(1, 32'h2B2A2928, 1, 14, 1, 0, 1, 8'h1D));
    tv.push_back(mk(0, 32'h0, 1, 13, 1, 0, 1, 8'h1E));
    tv.push_back(mk(1, 32'hFFFFFFFF, 1, 12, 0, 0, 1, 8'h1F));
    for (int j = 0; j < 12; j++)
      tv.push_back(mk(0, 32'h0, 1, 11 - j, 0, int'(j == 11), 1, 8'h20 + j));
    tv.push_back(mk(0, 32'h0, 0, 0, 0, 1, 0, 8'h2B));

    // Reset state before any clock edge.
    #2;
    check_all("reset", 0, 0, 1, 0, 8'h00);
    #6;
    arst_n = 1'b1;

    foreach (tv[i]) begin
      cyc(tv[i].we, tv[i].wd, tv[i].re);
      check_all($sformatf("vec%0d", i), int'(tv[i].lvl), int'(tv[i].full), int'(tv[i].empty),
                int'(tv[i].rv), int'(tv[i].rd));
    end

    // Read at empty is ignored and r_data holds.
    cyc(1'b0, 32'h0, 1'b1);
    check_all("underflow", 0, 0, 1, 0, 8'h2B);

    // 24 narrow words through 16 slots: order must survive the wrap.
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 32'h03020100 + 32'(k) * 32'h04040404, 1'b0);
      chk($sformatf("wrap w%0d level", k), 32'(level), 32'd4);
      for (int j = 0; j < 4; j++) begin
        cyc(1'b0, 32'h0, 1'b1);
        chk($sformatf("wrap r%0d_%0d r_data", k, j), 32'(r_data), 32'(4 * k + j));
        chk($sformatf("wrap r%0d_%0d r_valid", k, j), 32'(r_valid), 32'd1);
      end
    end

    // Asynchronous reset mid-operation at level 8.
    cyc(1'b1, 32'hA3A2A1A0, 1'b0);
    cyc(1'b1, 32'hA7A6A5A4, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);
    chk("pre-reset level", 32'(level), 32'd7);
    cyc(1'b1, 32'hABAAA9A8, 1'b1);
    chk("pre-reset level2", 32'(level), 32'd10);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    chk("pre-reset level3", 32'(level), 32'd8);
    #2;
    arst_n = 1'b0;
    #1;
    check_all("mid-reset", 0, 0, 1, 0, 8'h00);
    @(negedge clk);
    w_en   = 1'b1;
    w_data = 32'h44332211;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    w_en = 1'b0;
    check_all("post-reset write", 4, 0, 0, 0, 8'h00);
    cyc(1'b0, 32'h0, 1'b1);
    check_all("post-reset read", 3, 0, 0, 1, 8'h11);
    cyc(1'b0, 32'h0, 1'b0);
    check_all("post-reset idle", 3, 0, 0, 0, 8'h11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_fifo_w_wide_r_narrow.md
IOB_FIFO_W_WIDE_R_NARROW -- requirements
Module: iob_fifo_w_wide_r_narrow

Interface
REQ-001 The module SHALL have parameter W_DATA_W, default 32, meaning write-port data width.
REQ-002 The module SHALL have parameter R_DATA_W, default 8, meaning read-port data width; W_DATA_W/R_DATA_W = RATIO, a power of two >= 1.
REQ-003 The module SHALL have parameter R_ADDR_W, default 6, meaning the read-side address width; capacity is 2**R_ADDR_W narrow words, and W_ADDR_W = R_ADDR_W - log2(RATIO) is derived locally.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 arst_n  input  1  asynchronous, active-low reset.
REQ-007 w_en  input  1  write request, one wide word.
REQ-008 w_data  input  W_DATA_W  write data; lane 0 = bits [R_DATA_W-1:0].
REQ-009 w_full  output  1  high when fewer than RATIO narrow slots are free.
REQ-010 r_en  input  1  read request, one narrow word.
REQ-011 r_data  output  R_DATA_W  registered read data.
REQ-012 r_valid  output  1  high the cycle after an accepted read.
REQ-013 r_empty  output  1  high when level == 0.
REQ-014 level  output  R_ADDR_W+1  narrow words stored, 0..2**R_ADDR_W.

Function
REQ-015 A write SHALL be accepted on a rising edge with w_en=1 and w_full=0; it stores RATIO narrow words at consecutive addresses {wptr, lane}, where lane i holds w_data[(i+1)*R_DATA_W-1 -: R_DATA_W], so lane 0 is read first.
REQ-016 A write with w_full=1 SHALL be ignored: no storage change, no pointer or level change.
REQ-017 A read SHALL be accepted on a rising edge with r_en=1 and r_empty=0; r_data SHALL take mem[rptr] on that edge (1-cycle latency) and r_valid SHALL be 1 for the following cycle.
REQ-018 A read with r_empty=1 SHALL be ignored: r_data holds its previous value, r_valid=0, rptr and level unchanged.
REQ-019 r_valid SHALL be 0 in every cycle not following an accepted read; r_data SHALL hold its value between accepted reads.
REQ-020 wptr (W_ADDR_W bits) SHALL increment by 1 per accepted write and rptr (R_ADDR_W bits) by 1 per accepted read, both wrapping modulo their range with data order preserved across the wrap.
REQ-021 level SHALL update per edge as: +RATIO for write only, -1 for read only, +RATIO-1 for both accepted in the same cycle, unchanged otherwise.
REQ-022 Full/empty acceptance SHALL be evaluated from the registered level before the edge; a simultaneous read SHALL NOT free space for a write in the same cycle.
REQ-023 w_full SHALL equal (level > 2**R_ADDR_W - RATIO) and r_empty SHALL equal (level == 0), both derived only from registered state.
REQ-024 Storage SHALL be a single-clock array of 2**R_ADDR_W words of R_DATA_W bits, written RATIO lanes per accepted write, suitable for RAM inference; memory contents are not reset.

Reset
REQ-025 While arst_n=0, immediately and without a clock edge: wptr=0, rptr=0, level=0, r_data=0, r_valid=0, hence r_empty=1 and w_full=0.
REQ-026 Reset asserted mid-operation SHALL discard all stored data; the first accepted read after release SHALL return lane 0 of the first write after release.
REQ-027 Requests in the cycle reset releases SHALL follow REQ-015..REQ-021 normally.

Verification (W_DATA_W=32, R_DATA_W=8, R_ADDR_W=4: 16 slots, RATIO=4)
REQ-028 Reset: drive arst_n=0 with no clock -> r_empty=1, w_full=0, level=0, r_data=0x00, r_valid=0.
REQ-029 Order: write 0xDDCCBBAA, then r_en for 4 cycles -> r_data 0xAA, 0xBB, 0xCC, 0xDD, each with r_valid=1 one cycle after its r_en; level 4->0 and r_empty=1 at the end.
REQ-030 Full: 4 writes -> level=16, w_full=1; a 5th write is ignored (level stays 16); 1 read -> level=15, w_full=1; 4 reads total -> level=12, w_full=0.
REQ-031 Simultaneous: at level=4 assert w_en and r_en together -> level=7, r_valid=1 next cycle; at level=13 (w_full=1) both asserted -> write ignored, level=12.
REQ-032 Underflow and wrap: r_en at empty -> r_valid=0, r_data unchanged; then 6 writes of 0x03020100+k*0x04040404 interleaved with reads -> r_data returns 0x00,0x01,...,0x17 in order across the pointer wrap.
REQ-033 Reset mid-operation: at level=8 pulse arst_n low asynchronously -> level=0, r_empty=1 before the next edge; then write 0x44332211 -> first read returns 0x11.
